cordic_arbiter: RTL
===================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one cordic pipeline.
REQ-002 Parameter RAD_WIDTH, default 32: radian operand width.
REQ-003 Parameter DATA_WIDTH, default 16: sin/cos result width.
REQ-004 Parameter RES_DEPTH, default 32, power of two: result buffer depth and max outstanding operations; TAG_WIDTH = clog2(NUM_REQ).
REQ-005 There SHALL be one clock and one reset: the design SHALL use a single clock, and reset SHALL be synchronous and active-high.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  level; 1 = grant requests, 0 = stop granting and drain.
REQ-009 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-010 req_rad  in  NUM_REQ*RAD_WIDTH  packed operands; slice i belongs to requester i.
REQ-011 req_ready  out  NUM_REQ  one-hot-or-zero grant; the request is accepted when req_valid[i] & req_ready[i].
REQ-012 cordic_radian  out  RAD_WIDTH  operand to the cordic pipeline.
REQ-013 cordic_valid_in  out  1  operand strobe to the cordic pipeline.
REQ-014 cordic_sin, cordic_cos  in  DATA_WIDTH each  pipeline results.
REQ-015 cordic_valid_out  in  1  result strobe from the pipeline; it cannot be stalled.
REQ-016 res_valid  out  1  result available.
REQ-017 res_sin, res_cos  out  DATA_WIDTH each  result data.
REQ-018 res_tag  out  TAG_WIDTH  index of the requester that owns the result.
REQ-019 res_ready  in  1  consumer accepts the result when res_valid & res_ready.
REQ-020 busy  out  1  outstanding != 0.
REQ-021 drain_done  out  1  one-cycle pulse on the DRAIN->IDLE transition.
REQ-022 err_orphan  out  1  sticky; set when cordic_valid_out arrives while the tag queue is empty.

Function
REQ-023 The FSM SHALL have three states: IDLE, RUN and DRAIN.
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->IDLE when outstanding==0.
- DRAIN->RUN when enable=1 and outstanding!=0.
REQ-024 req_ready SHALL be nonzero only in RUN and only when outstanding < RES_DEPTH.
REQ-025 Arbitration SHALL be round-robin: the search starts at rr_ptr and takes the first i with req_valid[i]=1. req_ready is combinational from req_valid, rr_ptr, the state and outstanding.
REQ-026 On an accept by requester i, rr_ptr SHALL become (i+1) mod NUM_REQ on the next edge. rr_ptr SHALL be unchanged when nothing is accepted.
REQ-027 An accept at edge T SHALL produce cordic_valid_in=1 for exactly one cycle after T, with the registered operand on cordic_radian; otherwise cordic_valid_in=0 and cordic_radian holds its last value.
REQ-028 On each accept, tag i SHALL be pushed into an in-order tag queue of depth RES_DEPTH.
REQ-029 On cordic_valid_out=1, the head tag SHALL be popped. The tag, sin and cos SHALL be written together into the result FIFO (depth RES_DEPTH, first-word-fall-through).
REQ-030 res_valid SHALL equal result-FIFO not-empty. res_sin, res_cos and res_tag SHALL show the head entry, and the head is popped on res_valid & res_ready.
REQ-031 outstanding (width clog2(RES_DEPTH)+1) SHALL:
- +1 on an accept;
- -1 on a result pop;
- stay unchanged when both happen in the same cycle.
It therefore never exceeds RES_DEPTH, so the result FIFO never overflows.
REQ-032 A result SHALL be returned to the requester that issued it, and results SHALL come out in issue order.
REQ-033 A result push and a result pop in the same cycle SHALL both be done. A push and pop on the tag queue in the same cycle SHALL both be done.
REQ-034 Pointer wrap SHALL be modulo RES_DEPTH with no lost entries.
REQ-035 On cordic_valid_out with the tag queue empty:
- err_orphan SHALL be set;
- no result SHALL be written;
- outstanding SHALL be unchanged.

Reset
REQ-036 With reset=1 at an edge, the block SHALL go to:
- state IDLE, rr_ptr=0, outstanding=0;
- tag queue and result FIFO empty;
- cordic_valid_in=0, cordic_radian=0;
- req_ready=0, res_valid=0, res_sin=0, res_cos=0, res_tag=0;
- busy=0, drain_done=0, err_orphan=0.
REQ-037 A reset in the middle of an operation SHALL discard all in-flight tags and buffered results. Any cordic_valid_out that arrives after reset SHALL set err_orphan.

Verification
REQ-038 Reset then enable=1, req_valid=4'b0001, rad=0x3243F6A8 -> cordic_valid_in one cycle after the accept with that operand; the result comes out with res_tag=0.
REQ-039 req_valid=4'b1111 held, model latency 16, res_ready=1 -> grant order 0,1,2,3,0,...; res_tag sequence matches the grant order.
REQ-040 res_ready=0, all requesters valid -> exactly 32 accepts, then req_ready=0; one res pop -> exactly one further accept.
REQ-041 enable=0 after 5 accepts -> no further grants; the 5 results drain; drain_done pulses once when outstanding reaches 0; state is IDLE.
REQ-042 cordic_valid_out injected with no accepts -> err_orphan=1 and res_valid stays 0; reset clears err_orphan.
REQ-043 Reset asserted with 3 results outstanding -> busy=0, res_valid=0 and rr_ptr=0 on the next cycle.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one CORDIC pipeline between requesters.
// Tags ride an in-order queue; results return through a FWFT buffer.
module cordic_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RAD_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int RES_DEPTH  = 32,
  localparam int TAG_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*RAD_WIDTH-1:0]   req_rad,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [RAD_WIDTH-1:0]           cordic_radian,
  output logic                           cordic_valid_in,
  input  logic [DATA_WIDTH-1:0]          cordic_sin,
  input  logic [DATA_WIDTH-1:0]          cordic_cos,
  input  logic                           cordic_valid_out,
  output logic                           res_valid,
  output logic [DATA_WIDTH-1:0]          res_sin,
  output logic [DATA_WIDTH-1:0]          res_cos,
  output logic [TAG_WIDTH-1:0]           res_tag,
  input  logic                           res_ready,
  output logic                           busy,
  output logic                           drain_done,
  output logic                           err_orphan
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int RW = TAG_WIDTH + 2 * DATA_WIDTH;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(RES_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state;
  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [TAG_WIDTH-1:0] sel;
  logic [TAG_WIDTH-1:0] idx;
  logic [NUM_REQ-1:0]   grant;
  logic [AW:0]          outstanding;
  logic                 can_grant;
  logic                 accept;

  logic [TAG_WIDTH-1:0] tag_mem [RES_DEPTH];
  logic [AW-1:0]        tag_wr;
  logic [AW-1:0]        tag_rd;
  logic [AW:0]          tag_cnt;
  logic                 tag_empty;
  logic                 tag_pop;

  logic [RW-1:0]        res_mem [RES_DEPTH];
  logic [AW-1:0]        res_wr;
  logic [AW-1:0]        res_rd;
  logic [AW:0]          res_cnt;
  logic                 res_push;
  logic                 res_pop;
  logic [RW-1:0]        res_head;

  // Grant search starts at rr_ptr and wraps once around the requesters.
  always_comb begin
    grant     = '0;
    sel       = '0;
    idx       = '0;
    can_grant = (state == RUN) && (outstanding < DEPTH_V);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = TAG_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (grant == '0 && can_grant && req_valid[idx]) begin
        grant[idx] = 1'b1;
        sel        = idx;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (!enable) state <= DRAIN;
        DRAIN: begin
          if (outstanding == '0) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end else if (enable) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cordic_valid_in <= 1'b0;
      cordic_radian   <= '0;
      rr_ptr          <= '0;
    end else begin
      cordic_valid_in <= accept;
      if (accept) begin
        cordic_radian <= req_rad[int'(sel) * RAD_WIDTH +: RAD_WIDTH];
        rr_ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
      end
    end
  end

  assign tag_empty = (tag_cnt == '0);
  assign tag_pop   = cordic_valid_out & ~tag_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (accept) tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      case ({accept, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= sel;
  end

  assign res_push = tag_pop;
  assign res_valid = (res_cnt != '0);
  assign res_pop  = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_push) res_wr <= res_wr + 1'b1;
      if (res_pop) res_rd <= res_rd + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + 1'b1;
        2'b01:   res_cnt <= res_cnt - 1'b1;
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[res_wr] <= {tag_mem[tag_rd], cordic_sin, cordic_cos};
    end
  end

  // Head is masked so stale buffer contents never show while empty.
  assign res_head = res_valid ? res_mem[res_rd] : '0;
  assign res_tag  = res_head[RW-1 -: TAG_WIDTH];
  assign res_sin  = res_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign res_cos  = res_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, res_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy = (outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_orphan <= 1'b0;
    end else if (cordic_valid_out && tag_empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule
